plle2_drp_sequencer: RTL

Reconfigures a PLLE2_ADV at run time through its DRP port. On a start request it holds the PLL in reset and performs a read-modify-write of every register word in the selected configuration set. It then releases reset and waits for LOCKED. It sits between the board-level control logic (switches and reset shift register) and the PLLE2 test datapath. Configuration words come from an external synchronous ROM.

---
 rtl/plle2_drp_sequencer.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/plle2_drp_sequencer.sv
// Reconfigures a PLLE2_ADV over DRP: holds RST, read-modify-writes one ROM word set, releases RST, waits LOCKED.
// state | meaning: IDLE wait start | HOLD rst hold | FETCH rom addr + 1-cycle latency | READ read DEN
//   WAIT_RD read DRDY | WRITE write DEN | WAIT_WR write DRDY | RELEASE drop rst | WAIT_LOCK wait for lock
module plle2_drp_sequencer #(
  parameter int N_CFG        = 2,
  parameter int N_WORDS      = 21,
  parameter int RST_HOLD     = 4,
  parameter int DRDY_TIMEOUT = 63,
  parameter int LOCK_TIMEOUT = 65535,
  localparam int SEL_W       = (N_CFG > 1) ? $clog2(N_CFG) : 1,
  localparam int ROM_AW      = $clog2(N_CFG * N_WORDS)
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              I_START,
  input  logic [SEL_W-1:0]  I_SEL,
  output logic              O_BUSY,
  output logic              O_DONE,
  output logic              O_ERROR,
  output logic [ROM_AW-1:0] O_ROM_ADDR,
  input  logic [38:0]       I_ROM_DATA,
  output logic [6:0]        O_DADDR,
  output logic              O_DEN,
  output logic              O_DWE,
  output logic [15:0]       O_DI,
  input  logic [15:0]       I_DO,
  input  logic              I_DRDY,
  output logic              O_PLL_RST,
  input  logic              I_LOCKED
);

  localparam int IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [15:0]      HOLD_TC  = 16'(RST_HOLD - 1);
  localparam logic [15:0]      DRDY_TC  = 16'(DRDY_TIMEOUT - 1);
  localparam logic [15:0]      LOCK_TC  = 16'(LOCK_TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);
  localparam logic [SEL_W:0]   NCFG_X   = (SEL_W + 1)'(N_CFG);
  localparam logic [SEL_W-1:0] SEL_MAX  = SEL_W'(N_CFG - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_HOLD, S_FETCH, S_READ, S_WAIT_RD, S_WRITE, S_WAIT_WR, S_RELEASE, S_WAIT_LOCK
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       timer_q, timer_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic [6:0]        daddr_q, daddr_d;
  logic              den_q, den_d;
  logic              dwe_q, dwe_d;
  logic [15:0]       di_q, di_d;
  logic [15:0]       mask_q, mask_d;
  logic [15:0]       data_q, data_d;
  logic              pll_rst_q, pll_rst_d;
  logic              lock_s1_q, lock_s1_d;
  logic              lock_s2_q, lock_s2_d;
  logic [15:0]       rmw_word;

  function automatic logic [ROM_AW-1:0] rom_addr_f(input logic [SEL_W-1:0] s,
                                                  input logic [IDX_W-1:0] i);
    rom_addr_f = ROM_AW'(32'(s) * 32'(N_WORDS) + 32'(i));
  endfunction

  // bits set in keep_mask preserve the PLL's current register contents
  assign rmw_word = (I_DO & mask_q) | (data_q & ~mask_q);

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    idx_d      = idx_q;
    done_d     = 1'b0;
    err_d      = err_q;
    rom_addr_d = rom_addr_q;
    daddr_d    = daddr_q;
    den_d      = 1'b0;
    dwe_d      = 1'b0;
    di_d       = di_q;
    mask_d     = mask_q;
    data_d     = data_q;
    pll_rst_d  = pll_rst_q;
    lock_s1_d  = I_LOCKED;
    lock_s2_d  = lock_s1_q;

    case (state_q)
      S_IDLE: begin
        if (I_START) begin
          sel_d     = ({1'b0, I_SEL} >= NCFG_X) ? SEL_MAX : I_SEL;
          err_d     = 1'b0;
          idx_d     = '0;
          pll_rst_d = 1'b1;
          state_d   = S_HOLD;
        end
      end
      S_HOLD: begin
        if (timer_q == HOLD_TC) begin
          rom_addr_d = rom_addr_f(sel_q, idx_q);
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        if (timer_q == 16'd1) begin
          {daddr_d, mask_d, data_d} = I_ROM_DATA;
          den_d   = 1'b1;
          state_d = S_READ;
        end
      end
      S_READ: state_d = S_WAIT_RD;
      S_WAIT_RD: begin
        if (I_DRDY) begin
          di_d    = rmw_word;
          den_d   = 1'b1;
          dwe_d   = 1'b1;
          state_d = S_WRITE;
        end else if (timer_q == DRDY_TC) begin
          err_d     = 1'b1;
          pll_rst_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      S_WRITE: state_d = S_WAIT_WR;
      S_WAIT_WR: begin
        if (I_DRDY) begin
          if (idx_q == LAST_IDX) begin
            pll_rst_d = 1'b0;
            state_d   = S_RELEASE;
          end else begin
            idx_d      = idx_q + IDX_W'(1);
            rom_addr_d = rom_addr_f(sel_q, idx_q + IDX_W'(1));
            state_d    = S_FETCH;
          end
        end else if (timer_q == DRDY_TC) begin
          err_d     = 1'b1;
          pll_rst_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      S_RELEASE: state_d = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (lock_s2_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (timer_q == LOCK_TC) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q)       timer_d = '0;
    else if (timer_q != 16'hFFFF) timer_d = timer_q + 16'd1;
    else                          timer_d = timer_q;

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      sel_q      <= '0;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rom_addr_q <= '0;
      daddr_q    <= '0;
      den_q      <= 1'b0;
      dwe_q      <= 1'b0;
      di_q       <= '0;
      mask_q     <= '0;
      data_q     <= '0;
      pll_rst_q  <= 1'b0;
      lock_s1_q  <= 1'b0;
      lock_s2_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      sel_q      <= sel_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rom_addr_q <= rom_addr_d;
      daddr_q    <= daddr_d;
      den_q      <= den_d;
      dwe_q      <= dwe_d;
      di_q       <= di_d;
      mask_q     <= mask_d;
      data_q     <= data_d;
      pll_rst_q  <= pll_rst_d;
      lock_s1_q  <= lock_s1_d;
      lock_s2_q  <= lock_s2_d;
    end
  end

  assign O_BUSY     = busy_q;
  assign O_DONE     = done_q;
  assign O_ERROR    = err_q;
  assign O_ROM_ADDR = rom_addr_q;
  assign O_DADDR    = daddr_q;
  assign O_DEN      = den_q;
  assign O_DWE      = dwe_q;
  assign O_DI       = di_q;
  assign O_PLL_RST  = pll_rst_q;

endmodule
